// File: rtl/sun_serial_pkg.sv
// Shared types and helpers for the serial readout transmitter.
package sun_serial_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2
    } state_e;

    // Counter width for a range of n states; never below one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    // Widths for the default configuration (WIDTH=8, DIV=4).
    localparam int unsigned BITCNT_W = cnt_w(8);
    localparam int unsigned DIVCNT_W = cnt_w(4);

    // SCLK is high in the second half of each bit period.
    function automatic logic sclk_hi(input int unsigned divcnt, input int unsigned div);
        return divcnt >= (div / 2);
    endfunction

endpackage

// File: rtl/sun_serial_bittmr.sv
// Bit-period timer: counts CK cycles within one serial bit (or the trailing gap).
module sun_serial_bittmr
    import sun_serial_pkg::*;
#(
    parameter int unsigned DIV = 4
) (
    input  logic CK,
    input  logic R,
    input  logic run,
    input  logic clear,
    output logic bit_end,
    output logic half,
    output logic mid
);

    localparam int unsigned CntW = cnt_w(DIV);
    localparam logic [CntW-1:0] CntLast = CntW'(DIV - 1);
    localparam logic [CntW-1:0] CntMid  = CntW'((DIV / 2) - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    // Next count: clear wins, otherwise wrap at the end of the bit period.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (run) begin
            cnt_d = (cnt_q == CntLast) ? '0 : cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge CK or posedge R) begin
        if (R) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Decodes of the current count; mid marks the last low-SCLK cycle.
    always_comb begin
        bit_end = (cnt_q == CntLast);
        half    = sclk_hi(32'(cnt_q), DIV);
        mid     = (cnt_q == CntMid);
    end

endmodule

// File: rtl/sun_serial_tx.sv
// Parallel-to-serial readout transmitter: one word per VALID/READY handshake, shifted
// out MSB-first with a generated SCLK and a frame strobe SFRM. All outputs are flops.
module sun_serial_tx
    import sun_serial_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIV   = 4
) (
    input  logic             CK,
    input  logic             R,
    input  logic [WIDTH-1:0] DATA,
    input  logic             VALID,
    output logic             READY,
    output logic             SDO,
    output logic             SCLK,
    output logic             SFRM
);

    localparam int unsigned BitW = cnt_w(WIDTH);
    localparam logic [BitW-1:0] BitFirst = BitW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [BitW-1:0]  bitcnt_q, bitcnt_d;

    logic tmr_run, tmr_clear;
    logic tmr_bit_end, tmr_half, tmr_mid;

    logic ready_d, sdo_d, sclk_d, sfrm_d;

    sun_serial_bittmr #(
        .DIV (DIV)
    ) u_bittmr (
        .CK      (CK),
        .R       (R),
        .run     (tmr_run),
        .clear   (tmr_clear),
        .bit_end (tmr_bit_end),
        .half    (tmr_half),
        .mid     (tmr_mid)
    );

    // Next-state logic for the FSM, shift register and bit counter.
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bitcnt_d  = bitcnt_q;
        tmr_run   = 1'b0;
        tmr_clear = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                tmr_clear = 1'b1;
                if (VALID) begin
                    shreg_d  = DATA;
                    bitcnt_d = BitFirst;
                    state_d  = S_SHIFT;
                end
            end
            S_SHIFT: begin
                tmr_run = 1'b1;
                if (tmr_bit_end) begin
                    if (bitcnt_q == '0) begin
                        state_d = S_GAP;
                    end else begin
                        shreg_d  = {shreg_q[WIDTH-2:0], 1'b0};
                        bitcnt_d = bitcnt_q - 1'b1;
                    end
                end
            end
            S_GAP: begin
                tmr_run = 1'b1;
                if (tmr_bit_end) begin
                    tmr_clear = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output values for the coming cycle, decoded from next state so the flops line up
    // with the FSM. SCLK rises after the mid count and falls after the bit-end count.
    always_comb begin
        ready_d = (state_d == S_IDLE);
        sfrm_d  = (state_d == S_SHIFT);
        sdo_d   = (state_d == S_SHIFT) && shreg_d[WIDTH-1];
        sclk_d  = (state_d == S_SHIFT) && !tmr_clear && (tmr_mid || (tmr_half && !tmr_bit_end));
    end

    // State, datapath and output registers.
    always_ff @(posedge CK or posedge R) begin
        if (R) begin
            state_q  <= S_IDLE;
            shreg_q  <= '0;
            bitcnt_q <= '0;
            READY    <= 1'b1;
            SDO      <= 1'b0;
            SCLK     <= 1'b0;
            SFRM     <= 1'b0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            bitcnt_q <= bitcnt_d;
            READY    <= ready_d;
            SDO      <= sdo_d;
            SCLK     <= sclk_d;
            SFRM     <= sfrm_d;
        end
    end

endmodule

// File: tb/tb_sun_serial_tx.sv
// Directed bench for sun_serial_tx: an 8-bit/DIV=4 instance and a 2-bit/DIV=2 corner instance.
module tb_sun_serial_tx;

    logic CK = 1'b0;
    logic R;

    logic [7:0] data_a;
    logic       valid_a, ready_a, sdo_a, sclk_a, sfrm_a;
    logic [1:0] data_b;
    logic       valid_b, ready_b, sdo_b, sclk_b, sfrm_b;

    logic sel_b = 1'b0;
    logic obs_ready, obs_sdo, obs_sclk, obs_sfrm;

    int n_checks = 0;
    int n_errors = 0;

    always #5 CK = ~CK;

    sun_serial_tx #(
        .WIDTH (8),
        .DIV   (4)
    ) u_dut_a (
        .CK    (CK),
        .R     (R),
        .DATA  (data_a),
        .VALID (valid_a),
        .READY (ready_a),
        .SDO   (sdo_a),
        .SCLK  (sclk_a),
        .SFRM  (sfrm_a)
    );

    sun_serial_tx #(
        .WIDTH (2),
        .DIV   (2)
    ) u_dut_b (
        .CK    (CK),
        .R     (R),
        .DATA  (data_b),
        .VALID (valid_b),
        .READY (ready_b),
        .SDO   (sdo_b),
        .SCLK  (sclk_b),
        .SFRM  (sfrm_b)
    );

    // Select which instance the frame checker observes.
    always_comb begin
        obs_ready = sel_b ? ready_b : ready_a;
        obs_sdo   = sel_b ? sdo_b   : sdo_a;
        obs_sclk  = sel_b ? sclk_b  : sclk_a;
        obs_sfrm  = sel_b ? sfrm_b  : sfrm_a;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CK);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_ready"}, 32'(obs_ready), 32'd1);
        check({tag, "_sdo"},   32'(obs_sdo),   32'd0);
        check({tag, "_sclk"},  32'(obs_sclk),  32'd0);
        check({tag, "_sfrm"},  32'(obs_sfrm),  32'd0);
    endtask

    // Called in cycle k+1 after the accept edge; returns in cycle k+1+(w+1)*d.
    task automatic expect_frame(input int unsigned w, input int unsigned d,
                                input logic [7:0] word);
        logic [7:0] rx = 8'h00;
        logic       prev_sclk = 1'b0;
        for (int c = 0; c < int'(w * d); c++) begin
            check("frm_sfrm",  32'(obs_sfrm),  32'd1);
            check("frm_ready", 32'(obs_ready), 32'd0);
            check("frm_sdo",   32'(obs_sdo),   32'(word[int'(w) - 1 - c / int'(d)]));
            check("frm_sclk",  32'(obs_sclk),  32'((c % int'(d)) >= int'(d / 2)));
            // Receiver model: sample SDO on SCLK rising while SFRM is high.
            if (obs_sclk && !prev_sclk && obs_sfrm) begin
                rx = {rx[6:0], obs_sdo};
            end
            prev_sclk = obs_sclk;
            tick();
        end
        for (int g = 0; g < int'(d); g++) begin
            check("gap_sfrm",  32'(obs_sfrm),  32'd0);
            check("gap_sdo",   32'(obs_sdo),   32'd0);
            check("gap_sclk",  32'(obs_sclk),  32'd0);
            check("gap_ready", 32'(obs_ready), 32'd0);
            tick();
        end
        check("ready_back", 32'(obs_ready), 32'd1);
        check("end_sfrm",   32'(obs_sfrm),  32'd0);
        check("rx_word",    32'(rx),        32'(word));
    endtask

    initial begin
        R       = 1'b1;
        data_a  = 8'($urandom);
        valid_a = 1'b1;
        data_b  = 2'($urandom);
        valid_b = 1'b1;

        // Reset with random inputs applied.
        for (int i = 0; i < 3; i++) begin
            tick();
            data_a = 8'($urandom);
            data_b = 2'($urandom);
            sel_b  = 1'b0;
            #0 check_reset_vals("rst_a");
            sel_b  = 1'b1;
            #0 check_reset_vals("rst_b");
        end
        sel_b   = 1'b0;
        valid_a = 1'b0;
        valid_b = 1'b0;
        #3 R = 1'b0;

        // Idle after release.
        for (int i = 0; i < 3; i++) begin
            tick();
            check_reset_vals("idle");
        end

        // Single word 0xA5.
        data_a  = 8'hA5;
        valid_a = 1'b1;
        tick();
        valid_a = 1'b0;
        expect_frame(8, 4, 8'hA5);

        // VALID held: 0x01 then 0xFF back to back; DATA changes after accept.
        data_a  = 8'h01;
        valid_a = 1'b1;
        tick();
        data_a  = 8'hFF;
        expect_frame(8, 4, 8'h01);
        tick();
        valid_a = 1'b0;
        expect_frame(8, 4, 8'hFF);

        // Busy rules: DATA change and VALID pulses while busy are ignored.
        data_a  = 8'h3C;
        valid_a = 1'b1;
        tick();
        valid_a = 1'b0;
        fork
            expect_frame(8, 4, 8'h3C);
            begin
                tick();
                data_a = 8'h00;
                repeat (3) tick();
                data_a  = 8'h3C;
                valid_a = 1'b1;
                tick();
                valid_a = 1'b0;
                data_a  = 8'h00;
                repeat (14) tick();
                data_a  = 8'h3C;
                valid_a = 1'b1;
                tick();
                valid_a = 1'b0;
                data_a  = 8'h00;
            end
        join
        tick();
        check("no_queue_ready", 32'(obs_ready), 32'd1);
        check("no_queue_sfrm",  32'(obs_sfrm),  32'd0);

        // Reset in mid-frame, then a complete frame.
        data_a  = 8'hC3;
        valid_a = 1'b1;
        tick();
        valid_a = 1'b0;
        repeat (9) tick();
        check("pre_rst_sfrm", 32'(obs_sfrm), 32'd1);
        #2 R = 1'b1;
        #1 check_reset_vals("mid_rst");
        #1 R = 1'b0;
        tick();
        check_reset_vals("post_rst");
        data_a  = 8'h81;
        valid_a = 1'b1;
        tick();
        valid_a = 1'b0;
        expect_frame(8, 4, 8'h81);

        // Parameter corner: WIDTH=2, DIV=2.
        sel_b   = 1'b1;
        #0 check_reset_vals("b_idle");
        data_b  = 2'b10;
        valid_b = 1'b1;
        tick();
        valid_b = 1'b0;
        expect_frame(2, 2, 8'h02);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
